// File: rtl/comparator_seeker_if.sv
// Bundles the seeker's start/guess/verdict handshake and its status outputs.
// The master modport is the seeker; the slave modport is the responder or
// board wrapper that holds the secret and watches the status outputs.
interface comparator_seeker_if #(
    parameter int WIDTH = 4
);
    // Search control
    logic             start;

    // Candidate issued to the comparator's A side
    logic [WIDTH-1:0] guess;
    logic             guess_valid;

    // Verdict returned by the responder
    logic             result_valid;
    logic             A_eq_B;
    logic             A_lt_B;
    logic             A_gt_B;

    // Status
    logic             busy;
    logic             done;
    logic             found;
    logic             error;
    logic [3:0]       steps;

    // Seeker side
    modport master (
        input  start,
        input  result_valid,
        input  A_eq_B,
        input  A_lt_B,
        input  A_gt_B,
        output guess,
        output guess_valid,
        output busy,
        output done,
        output found,
        output error,
        output steps
    );

    // Responder / wrapper side
    modport slave (
        output start,
        output result_valid,
        output A_eq_B,
        output A_lt_B,
        output A_gt_B,
        input  guess,
        input  guess_valid,
        input  busy,
        input  done,
        input  found,
        input  error,
        input  steps
    );
endinterface

// File: rtl/comparator_seeker.sv
// Binary-search initiator for a magnitude comparator. Each guess is placed on
// the comparator's A side and held until a one-hot verdict arrives; the search
// range [lo, hi] narrows until equality, range exhaustion, or a malformed
// verdict. A one-cycle NEXT state separates consecutive guesses so the
// responder always sees guess_valid drop between transactions.
module comparator_seeker #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    comparator_seeker_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_NEXT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Range bounds carry one extra bit so lo = guess+1 at the top of the
    // range and the lo+hi sum never wrap.
    localparam logic [WIDTH:0]   RANGE_MAX = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH-1:0] GUESS_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] GUESS_MIN = '0;
    // First guess of every search: (0 + 2^WIDTH-1) >> 1
    localparam logic [WIDTH-1:0] GUESS_FIRST = {1'b0, {(WIDTH-1){1'b1}}};

    state_t           state_q, state_d;
    logic [WIDTH:0]   lo_q, lo_d;
    logic [WIDTH:0]   hi_q, hi_d;
    logic [WIDTH-1:0] guess_q, guess_d;
    logic [3:0]       steps_q, steps_d;
    logic             found_q, found_d;
    logic             error_q, error_d;

    logic [WIDTH:0]   mid_sum;
    logic [2:0]       verdict;
    logic             range_empty;

    assign mid_sum     = lo_q + hi_q;
    assign verdict     = {bus.A_eq_B, bus.A_lt_B, bus.A_gt_B};
    assign range_empty = (lo_q > hi_q);

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            lo_q    <= '0;
            hi_q    <= RANGE_MAX;
            guess_q <= '0;
            steps_q <= '0;
            found_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            guess_q <= guess_d;
            steps_q <= steps_d;
            found_q <= found_d;
            error_q <= error_d;
        end
    end

    // Next-state and datapath update for the search sequence.
    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        guess_d = guess_q;
        steps_d = steps_q;
        found_d = found_q;
        error_d = error_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                // A new search resets the range; result_valid is ignored here.
                if (bus.start) begin
                    state_d = ST_ISSUE;
                    lo_d    = '0;
                    hi_d    = RANGE_MAX;
                    guess_d = GUESS_FIRST;
                    steps_d = '0;
                    found_d = 1'b0;
                    error_d = 1'b0;
                end
            end

            ST_ISSUE: begin
                // Guess is held until the responder strobes a verdict.
                if (bus.result_valid) begin
                    steps_d = steps_q + 4'd1;
                    case (verdict)
                        3'b100: begin
                            state_d = ST_DONE;
                            found_d = 1'b1;
                        end
                        3'b010: begin
                            // Secret is above the guess.
                            if (guess_q == GUESS_MAX) begin
                                state_d = ST_DONE;
                            end else begin
                                lo_d    = {1'b0, guess_q} + 1'b1;
                                state_d = ST_NEXT;
                            end
                        end
                        3'b001: begin
                            // Secret is below the guess.
                            if (guess_q == GUESS_MIN) begin
                                state_d = ST_DONE;
                            end else begin
                                hi_d    = {1'b0, guess_q} - 1'b1;
                                state_d = ST_NEXT;
                            end
                        end
                        default: begin
                            // Zero or multiple verdict bits: abort the search.
                            state_d = ST_DONE;
                            error_d = 1'b1;
                        end
                    endcase
                end
            end

            ST_NEXT: begin
                // An inconsistent responder can empty the range; stop there.
                if (range_empty) begin
                    state_d = ST_DONE;
                end else begin
                    guess_d = mid_sum[WIDTH:1];
                    state_d = ST_ISSUE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs decode directly from the state register so that reset
    // clears them without waiting for a clock edge.
    always_comb begin
        bus.guess_valid = (state_q == ST_ISSUE);
        bus.busy        = (state_q == ST_ISSUE) || (state_q == ST_NEXT);
        bus.done        = (state_q == ST_DONE);
    end

    assign bus.guess = guess_q;
    assign bus.steps = steps_q;
    assign bus.found = found_q;
    assign bus.error = error_q;

endmodule

// File: tb/tb_comparator_seeker.sv
// Directed bench for comparator_seeker at WIDTH=4. The bench plays the
// responder, answering each guess against a chosen secret (or a scripted
// verdict) and comparing against hand-computed guess sequences.
module tb_comparator_seeker;

    localparam int WIDTH = 4;

    logic clk;
    logic reset;

    int vectors;
    int miscompares;

    comparator_seeker_if #(.WIDTH(WIDTH)) bus ();

    comparator_seeker #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle start pulse; returns at the negedge after the capturing edge.
    task automatic pulse_start();
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    // Wait (bounded) for guess_valid; counts a failure if it never comes.
    task automatic wait_guess(input string tag);
        int k;
        for (k = 0; k < 10; k++) begin
            if (bus.guess_valid === 1'b1) break;
            tick(1);
        end
        if (k == 10) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Answer the current guess after 'delay' idle cycles, checking that the
    // guess stays stable while waiting.
    task automatic respond(input logic [2:0] verdict, input int delay, input string tag);
        logic [WIDTH-1:0] held;
        held = bus.guess;
        for (int d = 0; d < delay; d++) begin
            tick(1);
            check({tag, "_hold_gv"}, 32'(bus.guess_valid), 32'd1);
            check({tag, "_hold_guess"}, 32'(bus.guess), 32'(held));
        end
        bus.result_valid = 1'b1;
        {bus.A_eq_B, bus.A_lt_B, bus.A_gt_B} = verdict;
        tick(1);
        bus.result_valid = 1'b0;
        {bus.A_eq_B, bus.A_lt_B, bus.A_gt_B} = 3'b000;
    endtask

    // Full search against 'secret' (or always-lt when always_lt=1); exp_list
    // holds the expected guesses, one nibble each, first guess in bits [3:0].
    task automatic run_search(input string tag, input int secret, input bit always_lt,
                              input logic [31:0] exp_list, input int n,
                              input bit exp_found, input int exp_steps);
        logic [2:0] v;
        pulse_start();
        for (int i = 0; i < n; i++) begin
            wait_guess(tag);
            check($sformatf("%s_guess%0d", tag, i), 32'(bus.guess), 32'(exp_list[4*i +: 4]));
            if (always_lt)                   v = 3'b010;
            else if (int'(bus.guess) == secret) v = 3'b100;
            else if (int'(bus.guess) < secret)  v = 3'b010;
            else                                v = 3'b001;
            respond(v, 0, tag);
        end
        check({tag, "_done"},  32'(bus.done),  32'd1);
        check({tag, "_found"}, 32'(bus.found), 32'(exp_found));
        check({tag, "_error"}, 32'(bus.error), 32'd0);
        check({tag, "_steps"}, 32'(bus.steps), 32'(exp_steps));
        check({tag, "_final_guess"}, 32'(bus.guess), 32'(exp_list[4*(n-1) +: 4]));
        check({tag, "_busy"},  32'(bus.busy),  32'd0);
        $display("search %s: secret=%0d guess=%0d found=%0b steps=%0d", tag, secret,
                 bus.guess, bus.found, bus.steps);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.result_valid = 1'b0;
        bus.A_eq_B = 1'b0;
        bus.A_lt_B = 1'b0;
        bus.A_gt_B = 1'b0;
        tick(3);

        // Reset state
        check("rst_guess", 32'(bus.guess), 32'd0);
        check("rst_gv",    32'(bus.guess_valid), 32'd0);
        check("rst_busy",  32'(bus.busy), 32'd0);
        check("rst_done",  32'(bus.done), 32'd0);
        check("rst_found", 32'(bus.found), 32'd0);
        check("rst_error", 32'(bus.error), 32'd0);
        check("rst_steps", 32'(bus.steps), 32'd0);
        reset = 1'b0;
        tick(1);

        // result_valid in IDLE does nothing
        bus.result_valid = 1'b1;
        bus.A_eq_B = 1'b1;
        tick(1);
        bus.result_valid = 1'b0;
        bus.A_eq_B = 1'b0;
        check("idle_rv_gv",    32'(bus.guess_valid), 32'd0);
        check("idle_rv_done",  32'(bus.done), 32'd0);
        check("idle_rv_steps", 32'(bus.steps), 32'd0);
        $display("idle result_valid pulse: gv=%0b done=%0b steps=%0d", bus.guess_valid, bus.done, bus.steps);

        // Directed searches
        run_search("s11",  11, 1'b0, 32'h000000B7, 2, 1'b1, 2);
        run_search("s0",    0, 1'b0, 32'h00000137, 4, 1'b1, 4);
        run_search("s15",  15, 1'b0, 32'h000FEDB7, 5, 1'b1, 5);
        run_search("allt",  0, 1'b1, 32'h000FEDB7, 5, 1'b0, 5);

        // Malformed verdicts: lt+gt, then all-zero
        pulse_start();
        check("bad2_first_guess", 32'(bus.guess), 32'd7);
        respond(3'b011, 0, "bad2");
        check("bad2_done",  32'(bus.done),  32'd1);
        check("bad2_error", 32'(bus.error), 32'd1);
        check("bad2_found", 32'(bus.found), 32'd0);
        check("bad2_steps", 32'(bus.steps), 32'd1);
        check("bad2_guess", 32'(bus.guess), 32'd7);
        $display("verdict lt+gt: done=%0b error=%0b steps=%0d", bus.done, bus.error, bus.steps);

        pulse_start();
        check("bad0_clr_error", 32'(bus.error), 32'd0);
        respond(3'b000, 0, "bad0");
        check("bad0_done",  32'(bus.done),  32'd1);
        check("bad0_error", 32'(bus.error), 32'd1);
        check("bad0_found", 32'(bus.found), 32'd0);
        check("bad0_steps", 32'(bus.steps), 32'd1);
        check("bad0_guess", 32'(bus.guess), 32'd7);
        $display("verdict none: done=%0b error=%0b steps=%0d", bus.done, bus.error, bus.steps);

        // Slow responder (secret 11), start during ISSUE, result_valid in NEXT
        pulse_start();
        check("slow_latency_gv", 32'(bus.guess_valid), 32'd1);
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        check("slow_start_ignored_steps", 32'(bus.steps), 32'd0);
        check("slow_start_ignored_gv",    32'(bus.guess_valid), 32'd1);
        respond(3'b010, 5, "slow");
        check("slow_next_gv",   32'(bus.guess_valid), 32'd0);
        check("slow_next_busy", 32'(bus.busy), 32'd1);
        bus.result_valid = 1'b1;
        bus.A_eq_B = 1'b1;
        tick(1);
        bus.result_valid = 1'b0;
        bus.A_eq_B = 1'b0;
        check("next_rv_steps", 32'(bus.steps), 32'd1);
        check("next_rv_guess", 32'(bus.guess), 32'd11);
        check("next_rv_gv",    32'(bus.guess_valid), 32'd1);
        respond(3'b100, 0, "slow2");
        check("slow_found", 32'(bus.found), 32'd1);
        check("slow_steps", 32'(bus.steps), 32'd2);
        bus.result_valid = 1'b1;
        bus.A_gt_B = 1'b1;
        tick(1);
        bus.result_valid = 1'b0;
        bus.A_gt_B = 1'b0;
        check("done_rv_done",  32'(bus.done), 32'd1);
        check("done_rv_steps", 32'(bus.steps), 32'd2);
        $display("slow responder: guess=%0d found=%0b steps=%0d", bus.guess, bus.found, bus.steps);

        // Asynchronous reset during the second ISSUE
        pulse_start();
        respond(3'b010, 0, "rst1");
        wait_guess("rst2");
        check("pre_rst_steps", 32'(bus.steps), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_gv",    32'(bus.guess_valid), 32'd0);
        check("async_rst_busy",  32'(bus.busy), 32'd0);
        check("async_rst_steps", 32'(bus.steps), 32'd0);
        $display("async reset mid-search: gv=%0b busy=%0b steps=%0d", bus.guess_valid, bus.busy, bus.steps);
        tick(2);
        reset = 1'b0;
        tick(1);

        // start and result_valid together in IDLE: start wins
        bus.result_valid = 1'b1;
        bus.A_eq_B = 1'b1;
        pulse_start();
        bus.result_valid = 1'b0;
        bus.A_eq_B = 1'b0;
        check("restart_gv",    32'(bus.guess_valid), 32'd1);
        check("restart_guess", 32'(bus.guess), 32'd7);
        check("restart_steps", 32'(bus.steps), 32'd0);
        respond(3'b100, 0, "restart");
        check("restart_found", 32'(bus.found), 32'd1);
        check("restart_steps_end", 32'(bus.steps), 32'd1);
        $display("restart after reset: guess=%0d found=%0b steps=%0d", bus.guess, bus.found, bus.steps);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/comparator_seeker.md
Name: comparator_seeker

Overview:
- Initiator-side counterpart of the 2-input magnitude comparator.
- Issues a candidate value on the comparator's A side and consumes the returned A_eq_B / A_lt_B / A_gt_B verdict, with B an unknown secret.
- Binary-searches until equality, so a board-level wrapper can find a switch-set secret and show the guess and step count on the HEX displays.
- Handshake is valid/response; the responder may take any number of cycles to answer.

Parameters:
- WIDTH, 4, width of guess and secret; legal range 2..8.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  one-cycle request to begin a search; honoured only in IDLE or DONE.
- guess  output  WIDTH  current candidate (comparator A); stable while guess_valid=1.
- guess_valid  output  1  high while a guess awaits a verdict.
- result_valid  input  1  responder strobe; verdict inputs sampled only when result_valid=1 and guess_valid=1.
- A_eq_B  input  1  guess == secret.
- A_lt_B  input  1  guess < secret.
- A_gt_B  input  1  guess > secret.
- busy  output  1  high in ISSUE and NEXT.
- done  output  1  high in DONE.
- found  output  1  last search ended on equality; valid when done=1.
- error  output  1  last search aborted on a non-one-hot verdict; valid when done=1.
- steps  output  4  verdicts consumed in current/last search.

Behaviour:
- Reset values: all outputs 0; state IDLE; lo=0; hi=2^WIDTH-1.
- States: IDLE, ISSUE, NEXT, DONE.
- IDLE/DONE + start=1:
  - Next cycle enters ISSUE.
  - lo=0, hi=2^WIDTH-1, guess=(lo+hi)>>1 (7 for WIDTH=4).
  - steps, found and error cleared.
  - guess_valid=1 on the first ISSUE cycle, so latency start→guess_valid is 1 clock.
- ISSUE: guess_valid=1; guess held until a verdict is accepted. A verdict is accepted when result_valid=1; steps increments by 1 on acceptance.
  - A_eq_B only: go DONE, found=1.
  - A_lt_B only, guess==2^WIDTH-1: go DONE, found=0.
  - A_lt_B only, otherwise: lo=guess+1, go NEXT.
  - A_gt_B only, guess==0: go DONE, found=0.
  - A_gt_B only, otherwise: hi=guess-1, go NEXT.
  - Any other verdict combination (zero or more than one bit set): go DONE, error=1, found=0.
- NEXT: lasts exactly 1 cycle with guess_valid=0, which gives the responder a visible transaction gap.
  - lo>hi: go DONE, found=0.
  - Otherwise: guess=(lo+hi)>>1, return to ISSUE.
- Arithmetic: lo, hi and the sum are held in WIDTH+1 bits, so there is no wrap-around; guess is the low WIDTH bits of the shifted sum.
- DONE:
  - done=1; guess holds the last issued value; found/error/steps hold.
  - Stays in DONE until start.
- Ignored inputs:
  - result_valid outside ISSUE has no effect.
  - start in ISSUE or NEXT has no effect; a search in flight is not restartable except by reset.
- Step bound: a consistent responder yields found=1 within WIDTH+1 verdicts; steps never exceeds 9 at WIDTH=8.
- Reset mid-operation: outputs return to reset values asynchronously; the search is abandoned; IDLE after release.
- Simultaneous events: start and result_valid both high in IDLE → start wins and result_valid is ignored.

Test Plan:
- WIDTH=4, secret 11, responder answers next cycle → guesses 7 (lt), 11 (eq); done=1, found=1, steps=2, guess=11.
- Secret 0 → guesses 7, 3, 1, 0; found=1, steps=4. Secret 15 → guesses 7, 11, 13, 14, 15; found=1, steps=5.
- Responder always answers lt → guesses 7, 11, 13, 14, 15; DONE with found=0, error=0, steps=5.
- First verdict lt and gt both set → DONE next cycle, error=1, found=0, steps=1, guess=7. All-zero verdict → same result.
- Responder delays result_valid by 5 cycles → guess_valid and guess stay stable throughout. result_valid pulses during NEXT or IDLE → no change to steps, guess or state.
- Reset asserted during second ISSUE → guess_valid, busy and steps drop to 0 with no clock edge. Release, then start → search restarts with guess=7.
